// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with a start/busy/done handshake.
// ADD/SUB/AND/OR finish in one cycle; MUL/UMULL/SMULL use an iterative
// radix-2 shift-add multiplier producing a full 2*WIDTH-bit product.
// Optional feature macro: ALU_SMULL_EN (signed SMULL on opcode 111 with an
// extra sign-fix cycle). Without it, opcode 111 behaves exactly like UMULL.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultExtra,
  output logic [3:0]       ALUFlags
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b101;
`ifdef ALU_SMULL_EN
  localparam logic [2:0] OP_SMULL = 3'b111;
`endif

  typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;

  state_t state_q, state_d;

  // Multiplier datapath: the multiplicand is kept 2*WIDTH wide and shifted
  // left each iteration, so "multiplicand << count" needs no barrel shifter.
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_step;

`ifdef ALU_SMULL_EN
  logic               neg_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
`endif

  logic               is_mul;
  logic               sub;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [3:0]         alu_flags;

  logic               out_load, use_prod;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_d, extra_d;
  logic [3:0]         flags_d;

  // Single-cycle arithmetic/logic result and flags straight from the inputs.
  // NOTE: every signal written in an always_comb gets a value before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_mul  = ALUControl[2] & (ALUControl[1] | ALUControl[0]);
    sub     = (ALUControl == OP_SUB);
    sum     = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH{1'b0}}, sub};
    alu_res = sum[WIDTH-1:0];
    alu_c   = sum[WIDTH];
    alu_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum[WIDTH-1]);
    case (ALUControl)
      OP_AND: begin
        alu_res = a & b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      OP_OR: begin
        alu_res = a | b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      default: ;
    endcase
    alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
  end

  // One shift-add step: add the aligned multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

`ifdef ALU_SMULL_EN
  // Operand magnitudes for SMULL; INT_MIN maps to 2^(WIDTH-1) read as unsigned.
  always_comb begin
    mag_a = a[WIDTH-1] ? -a : a;
    mag_b = b[WIDTH-1] ? -b : b;
  end
`endif

  // FSM next state, handshake outputs, and the value to register on entering DONE.
  always_comb begin
    state_d  = state_q;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    out_load = 1'b0;
    use_prod = 1'b0;
    prod     = acc_step;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul) begin
            state_d = MUL;
          end else begin
            state_d  = DONE;
            out_load = 1'b1;
          end
        end
      end
      MUL: begin
        if (count_q == LAST) begin
          state_d  = DONE;
          out_load = 1'b1;
          use_prod = 1'b1;
`ifdef ALU_SMULL_EN
          if (op_q == OP_SMULL) begin
            state_d  = FIX;
            out_load = 1'b0;
            use_prod = 1'b0;
          end
`endif
        end
      end
`ifdef ALU_SMULL_EN
      FIX: begin
        state_d  = DONE;
        out_load = 1'b1;
        use_prod = 1'b1;
        prod     = neg_q ? -acc_q : acc_q;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    res_d   = alu_res;
    extra_d = '0;
    flags_d = alu_flags;
    if (use_prod) begin
      if (op_q == OP_MUL) begin
        res_d   = prod[WIDTH-1:0];
        flags_d = {prod[WIDTH-1], (prod[WIDTH-1:0] == '0), 2'b00};
      end else begin
        res_d   = prod[WIDTH-1:0];
        extra_d = prod[2*WIDTH-1:WIDTH];
        flags_d = {prod[2*WIDTH-1], (prod == '0), 2'b00};
      end
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Multiplier operand capture on accept, then one shift-add iteration per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
`ifdef ALU_SMULL_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start && is_mul) begin
            op_q     <= ALUControl;
            acc_q    <= '0;
            count_q  <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
`ifdef ALU_SMULL_EN
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            if (ALUControl == OP_SMULL) begin
              mcand_q  <= {{WIDTH{1'b0}}, mag_a};
              mplier_q <= mag_b;
            end
`endif
          end
        end
        MUL: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Output registers: updated only on the edge that enters DONE, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Result      <= '0;
      ResultExtra <= '0;
      ALUFlags    <= '0;
    end else if (out_load) begin
      Result      <= res_d;
      ResultExtra <= extra_d;
      ALUFlags    <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle (WIDTH=32).
// Stimulus pushes the reference-model answer into a queue; an independent
// monitor pops and compares whenever done is seen. Honours ALU_SMULL_EN.
module tb_alu_multicycle;

  localparam int W = 32;
  localparam int T = 10;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] RSV = 3'b100, MULO = 3'b101, UMULL = 3'b110, SMULL = 3'b111;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   ALUControl = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] Result, ResultExtra;
  logic [3:0]   ALUFlags;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ALUControl  (ALUControl),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .Result      (Result),
    .ResultExtra (ResultExtra),
    .ALUFlags    (ALUFlags)
  );

  always #(T/2) clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] extra;
    logic [3:0]   flags;
    int           lat;
    time          t0;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint s;
    logic [63:0] p;
    logic   c, v, wide;
    e.extra = '0;
    c = 1'b0; v = 1'b0; wide = 1'b0; p = '0;
    e.lat = 1;
    case (op)
      SUB: begin
        e.res = x - y;
        c     = (x >= y);
        s     = longint'($signed(x)) - longint'($signed(y));
        v     = (s != longint'($signed(e.res)));
      end
      AND_: e.res = x & y;
      OR_:  e.res = x | y;
      MULO: begin
        p = {32'b0, x} * {32'b0, y};
        e.res = p[W-1:0];
        e.lat = W + 1;
      end
      UMULL: begin
        p = {32'b0, x} * {32'b0, y};
        wide = 1'b1;
        e.lat = W + 1;
      end
      SMULL: begin
`ifdef ALU_SMULL_EN
        p = longint'($signed(x)) * longint'($signed(y));
        e.lat = W + 2;
`else
        p = {32'b0, x} * {32'b0, y};
        e.lat = W + 1;
`endif
        wide = 1'b1;
      end
      default: begin
        e.res = x + y;
        c     = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF;
        s     = longint'($signed(x)) + longint'($signed(y));
        v     = (s != longint'($signed(e.res)));
      end
    endcase
    if (wide) begin
      e.res   = p[W-1:0];
      e.extra = p[63:32];
      e.flags = {p[63], (p == 64'd0), 2'b00};
    end else begin
      e.flags = {e.res[W-1], (e.res == '0), c, v};
    end
    e.t0 = 0;
    e.name = "";
    return e;
  endfunction

  // Monitor: pop one expectation for each done pulse and compare.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 Result=0x%0h, expected no done", Result);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_result"}, 64'(Result), 64'(e.res));
        check({e.name, "_extra"},  64'(ResultExtra), 64'(e.extra));
        check({e.name, "_flags"},  64'(ALUFlags), 64'(e.flags));
        check({e.name, "_latency"}, 64'(($time - e.t0) / T), 64'(e.lat));
        check({e.name, "_busy"},   64'(busy), 64'd1);
      end
    end
  end

  // Wait (bounded) for done, then one more cycle so the DUT is back in IDLE.
  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, k);
    end
    @(negedge clk);
  endtask

  // Issue one op from an idle negedge, then scramble inputs to show they are not used.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input string name);
    exp_t e;
    e = model(op, x, y);
    e.name = name;
    e.t0 = $time;
    exp_q.push_back(e);
    ALUControl = op; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ALUControl = 3'($urandom);
    a = $urandom;
    b = $urandom;
    wait_done(name);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    check("reset_result", 64'(Result), 64'd0);
    check("reset_extra",  64'(ResultExtra), 64'd0);
    check("reset_flags",  64'(ALUFlags), 64'd0);
    check("reset_busy",   64'(busy), 64'd0);
    check("reset_done",   64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed scenarios.
    issue(ADD,   32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");
    issue(SUB,   32'd5,         32'd5,         "sub_zero");
    issue(AND_,  32'hF0F0_F0F0, 32'h0FF0_0FF0, "and");
    issue(OR_,   32'hF0F0_0000, 32'h0000_000F, "or");
    issue(RSV,   32'hFFFF_FFFF, 32'h0000_0001, "rsv_add");
    issue(UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umull_max");
    issue(SMULL, 32'hFFFF_FFFE, 32'd3,         "smull_neg");
    issue(SMULL, 32'h8000_0000, 32'h8000_0000, "smull_intmin");
    issue(SMULL, 32'h8000_0000, 32'd1,         "smull_intmin_x1");

    // Second start while busy must be ignored.
    e = model(MULO, 32'd7, 32'd6);
    e.name = "mul_ignore";
    e.t0 = $time;
    exp_q.push_back(e);
    ALUControl = MULO; a = 32'd7; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    ALUControl = ADD; a = 32'd1; b = 32'd1; start = 1'b1;
    check("mul_ignore_busy_mid", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_ignore");

    // Reset during a UMULL aborts without a done pulse.
    ALUControl = UMULL; a = $urandom; b = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_result", 64'(Result), 64'd0);
    check("abort_extra",  64'(ResultExtra), 64'd0);
    check("abort_flags",  64'(ALUFlags), 64'd0);
    check("abort_busy",   64'(busy), 64'd0);
    check("abort_done",   64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_done_hold", 64'(done), 64'd0);
      check("abort_busy_hold", 64'(busy), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    issue(ADD, 32'd2, 32'd2, "add_after_reset");

    // Randomised operations.
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), "rand");
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
